// File: rtl/usb_rx_packet_sequencer_if.sv
// USB receive sequencer bit-stream and framing bundle.
// Decoder side drives bits/EOP, sequencer returns bytes and pulses.
interface usb_rx_packet_sequencer_if;
  logic       rxBitValid_i;
  logic       rxBit_i;
  logic       eopDetected_i;
  logic       rxActive_o;
  logic [7:0] byte_o;
  logic       byteValid_o;
  logic       rxDone_o;
  logic       stuffError_o;
  logic       alignError_o;
  logic       overflowError_o;

  modport master (
    output rxBitValid_i,
    output rxBit_i,
    output eopDetected_i,
    input  rxActive_o,
    input  byte_o,
    input  byteValid_o,
    input  rxDone_o,
    input  stuffError_o,
    input  alignError_o,
    input  overflowError_o
  );

  modport slave (
    input  rxBitValid_i,
    input  rxBit_i,
    input  eopDetected_i,
    output rxActive_o,
    output byte_o,
    output byteValid_o,
    output rxDone_o,
    output stuffError_o,
    output alignError_o,
    output overflowError_o
  );
endinterface

// File: rtl/usb_rx_packet_sequencer.sv
// USB receive sequencer: SYNC hunt, bit unstuffing, byte assembly
// and EOP framing with single-cycle done/error pulses.
module usb_rx_packet_sequencer #(
  parameter int SYNC_MIN_ZEROS = 5,
  parameter int MAX_BYTES      = 1027
) (
  input logic                     clk12_i,
  input logic                     rst_i,
  usb_rx_packet_sequencer_if.slave bus
);

  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam int BW = $clog2(MAX_BYTES + 1);

  typedef enum logic [1:0] {
    HUNT,
    DATA,
    DRAIN
  } state_t;

  state_t        r_state, w_state;
  logic [ZW-1:0] r_zeros, w_zeros;
  logic [2:0]    r_ones, w_ones;
  logic [2:0]    r_bitcnt, w_bitcnt;
  logic [BW-1:0] r_bytecnt, w_bytecnt;
  logic [6:0]    r_shift, w_shift;
  logic [7:0]    r_byte, w_byte;
  logic          r_byteValid, w_byteValid;
  logic          r_done, w_done;
  logic          r_stuff, w_stuff;
  logic          r_align, w_align;
  logic          r_ovf, w_ovf;

  logic          w_eop;
  logic          w_bitValid;
  logic          w_bit;

  // EOP wins over a coincident bit in every state
  assign w_eop      = bus.eopDetected_i;
  assign w_bitValid = bus.rxBitValid_i && !bus.eopDetected_i;
  assign w_bit      = bus.rxBit_i;

  // State register and all datapath/pulse registers
  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      r_state     <= HUNT;
      r_zeros     <= '0;
      r_ones      <= '0;
      r_bitcnt    <= '0;
      r_bytecnt   <= '0;
      r_shift     <= '0;
      r_byte      <= '0;
      r_byteValid <= 1'b0;
      r_done      <= 1'b0;
      r_stuff     <= 1'b0;
      r_align     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_zeros     <= w_zeros;
      r_ones      <= w_ones;
      r_bitcnt    <= w_bitcnt;
      r_bytecnt   <= w_bytecnt;
      r_shift     <= w_shift;
      r_byte      <= w_byte;
      r_byteValid <= w_byteValid;
      r_done      <= w_done;
      r_stuff     <= w_stuff;
      r_align     <= w_align;
      r_ovf       <= w_ovf;
    end
  end

  // Next-state, counters and pulse generation
  always_comb begin
    w_state     = r_state;
    w_zeros     = r_zeros;
    w_ones      = r_ones;
    w_bitcnt    = r_bitcnt;
    w_bytecnt   = r_bytecnt;
    w_shift     = r_shift;
    w_byte      = r_byte;
    w_byteValid = 1'b0;
    w_done      = 1'b0;
    w_stuff     = 1'b0;
    w_align     = 1'b0;
    w_ovf       = 1'b0;

    unique case (r_state)
      HUNT: begin
        if (w_eop) begin
          w_zeros = '0;
        end else if (w_bitValid) begin
          if (!w_bit) begin
            if (r_zeros != ZW'(SYNC_MIN_ZEROS))
              w_zeros = r_zeros + ZW'(1);
          end else if (r_zeros == ZW'(SYNC_MIN_ZEROS)) begin
            // SYNC trailing 1 seeds the stuffing run
            w_state   = DATA;
            w_zeros   = '0;
            w_ones    = 3'd1;
            w_bitcnt  = '0;
            w_bytecnt = '0;
          end else begin
            w_zeros = '0;
          end
        end
      end

      DATA: begin
        if (w_eop) begin
          w_state = HUNT;
          if (r_bitcnt == 3'd0 && r_bytecnt != '0)
            w_done = 1'b1;
          else
            w_align = 1'b1;
        end else if (w_bitValid) begin
          if (r_ones == 3'd6) begin
            if (!w_bit) begin
              w_ones = '0;
            end else begin
              w_stuff = 1'b1;
              w_state = DRAIN;
            end
          end else begin
            w_shift  = {w_bit, r_shift[6:1]};
            w_ones   = w_bit ? r_ones + 3'd1 : 3'd0;
            w_bitcnt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              if (r_bytecnt == BW'(MAX_BYTES)) begin
                w_ovf   = 1'b1;
                w_state = DRAIN;
              end else begin
                w_byte      = {w_bit, r_shift};
                w_byteValid = 1'b1;
                w_bytecnt   = r_bytecnt + BW'(1);
              end
            end
          end
        end
      end

      DRAIN: begin
        if (w_eop)
          w_state = HUNT;
      end

      default: begin
        w_state = HUNT;
      end
    endcase
  end

  assign bus.rxActive_o      = (r_state != HUNT);
  assign bus.byte_o          = r_byte;
  assign bus.byteValid_o     = r_byteValid;
  assign bus.rxDone_o        = r_done;
  assign bus.stuffError_o    = r_stuff;
  assign bus.alignError_o    = r_align;
  assign bus.overflowError_o = r_ovf;

endmodule

// File: tb/tb_usb_rx_packet_sequencer.sv
// Bench for usb_rx_packet_sequencer: scoreboarded byte stream
// plus pulse counting per scenario.
module tb_usb_rx_packet_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  usb_rx_packet_sequencer_if bus ();

  usb_rx_packet_sequencer #(
    .SYNC_MIN_ZEROS(5),
    .MAX_BYTES     (2)
  ) u_dut (
    .clk12_i(clk),
    .rst_i  (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cnt_bv, cnt_done, cnt_stuff, cnt_align, cnt_ovf;
  int tb_ones;
  logic [7:0] exp_q[$];

  // Monitor: scoreboard bytes and count pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.byteValid_o) begin
        logic [7:0] e;
        cnt_bv++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected byte got=%02h expected none",
                   bus.byte_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.byte_o !== e) begin
            errors++;
            $display("FAIL sb_byte got=%02h expected=%02h",
                     bus.byte_o, e);
          end
        end
      end
      if (bus.rxDone_o)        cnt_done++;
      if (bus.stuffError_o)    cnt_stuff++;
      if (bus.alignError_o)    cnt_align++;
      if (bus.overflowError_o) cnt_ovf++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clr();
    cnt_bv = 0; cnt_done = 0; cnt_stuff = 0;
    cnt_align = 0; cnt_ovf = 0;
  endtask

  task automatic idle(input int n);
    bus.rxBitValid_i  = 1'b0;
    bus.eopDetected_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus.rxBitValid_i = 1'b1;
    bus.rxBit_i      = b;
    @(negedge clk);
    bus.rxBitValid_i = 1'b0;
  endtask

  task automatic send_eop();
    bus.eopDetected_i = 1'b1;
    @(negedge clk);
    bus.eopDetected_i = 1'b0;
  endtask

  task automatic send_sync(input int nz);
    repeat (nz) send_bit(1'b0);
    send_bit(1'b1);
    tb_ones = 1;
  endtask

  // Transmit-side stuffing model: insert 0 after six ones
  task automatic send_data(input logic b);
    if (tb_ones == 6) begin
      send_bit(1'b0);
      tb_ones = 0;
    end
    send_bit(b);
    tb_ones = b ? tb_ones + 1 : 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit emit);
    if (emit) exp_q.push_back(b);
    for (int i = 0; i < 8; i++) send_data(b[i]);
  endtask

  task automatic chk_counts(input string nm, input int bv,
                            input int dn, input int st,
                            input int al, input int ov);
    idle(2);
    checks++;
    if (cnt_bv !== bv || cnt_done !== dn || cnt_stuff !== st ||
        cnt_align !== al || cnt_ovf !== ov) begin
      errors++;
      $display("FAIL %s counts got bv=%0d dn=%0d st=%0d al=%0d ov=%0d expected bv=%0d dn=%0d st=%0d al=%0d ov=%0d",
               nm, cnt_bv, cnt_done, cnt_stuff, cnt_align, cnt_ovf,
               bv, dn, st, al, ov);
    end
  endtask

  task automatic chk_idle_outs(input string nm);
    checks++;
    if ({bus.rxActive_o, bus.byte_o, bus.byteValid_o, bus.rxDone_o,
         bus.stuffError_o, bus.alignError_o,
         bus.overflowError_o} !== 14'd0) begin
      errors++;
      $display("FAIL %s outputs got act=%b byte=%02h bv=%b dn=%b st=%b al=%b ov=%b expected all 0",
               nm, bus.rxActive_o, bus.byte_o, bus.byteValid_o,
               bus.rxDone_o, bus.stuffError_o, bus.alignError_o,
               bus.overflowError_o);
    end
  endtask

  task automatic chk_bit(input string nm, input logic got,
                         input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b expected=%b", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    chk_idle_outs("reset");
  endtask

  task automatic test_basic_a5();
    clr();
    send_sync(7);
    chk_bit("a5_active", bus.rxActive_o, 1'b1);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 8; i++) send_data(i[0] ? ((8'hA5 >> i) & 1) != 0
                                               : ((8'hA5 >> i) & 1) != 0);
    chk_bit("a5_bv_latency", bus.byteValid_o, 1'b1);
    checks++;
    if (bus.byte_o !== 8'hA5) begin
      errors++;
      $display("FAIL a5_byte got=%02h expected=a5", bus.byte_o);
    end
    send_eop();
    chk_bit("a5_done", bus.rxDone_o, 1'b1);
    chk_bit("a5_inactive", bus.rxActive_o, 1'b0);
    chk_counts("a5", 1, 1, 0, 0, 0);
  endtask

  task automatic test_stuffing();
    clr();
    send_sync(7);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_eop();
    chk_counts("stuff_ok", 2, 1, 0, 0, 0);
    clr();
    send_sync(7);
    send_byte(8'hFC, 1'b1);
    send_eop();
    chk_counts("stuff_pending_eop", 1, 1, 0, 0, 0);
  endtask

  task automatic test_stuff_error();
    clr();
    send_sync(7);
    repeat (6) send_bit(1'b1);
    chk_bit("stuff_err_pulse", bus.stuffError_o, 1'b1);
    send_bit(1'b1);
    repeat (8) send_bit(1'b0);
    chk_bit("stuff_drain_active", bus.rxActive_o, 1'b1);
    send_eop();
    chk_bit("stuff_hunt", bus.rxActive_o, 1'b0);
    chk_counts("stuff_err", 0, 0, 1, 0, 0);
  endtask

  task automatic test_sync_hunt();
    clr();
    send_sync(4);
    chk_bit("sync4_reject", bus.rxActive_o, 1'b0);
    send_sync(5);
    chk_bit("sync5_accept", bus.rxActive_o, 1'b1);
    send_eop();
    chk_bit("sync_eop_align", bus.alignError_o, 1'b1);
    chk_counts("sync_hunt", 0, 0, 0, 1, 0);
  endtask

  task automatic test_align();
    clr();
    send_sync(7);
    send_byte(8'h5A, 1'b1);
    send_data(1'b1);
    send_data(1'b0);
    send_data(1'b1);
    send_eop();
    chk_counts("align_partial", 1, 0, 0, 1, 0);
    clr();
    send_sync(7);
    for (int i = 0; i < 7; i++) send_data(1'b0);
    bus.rxBitValid_i  = 1'b1;
    bus.rxBit_i       = 1'b1;
    bus.eopDetected_i = 1'b1;
    @(negedge clk);
    bus.rxBitValid_i  = 1'b0;
    bus.eopDetected_i = 1'b0;
    chk_bit("eop_8th_align", bus.alignError_o, 1'b1);
    chk_bit("eop_8th_nobv", bus.byteValid_o, 1'b0);
    chk_counts("eop_8th", 0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    clr();
    send_sync(7);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    chk_bit("ovf_pulse", bus.overflowError_o, 1'b1);
    chk_bit("ovf_nobv", bus.byteValid_o, 1'b0);
    send_byte(8'h44, 1'b0);
    send_eop();
    chk_counts("overflow", 2, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid();
    clr();
    send_sync(7);
    send_data(1'b1);
    send_data(1'b0);
    send_data(1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outs("rst_mid");
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk_bit("rst_mid_hunt", bus.rxActive_o, 1'b0);
    send_eop();
    chk_counts("rst_mid", 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    clr();
    send_sync(7);
    send_byte(8'hA5, 1'b1);
    send_eop();
    send_sync(6);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_eop();
    chk_counts("back_to_back", 3, 2, 0, 0, 0);
  endtask

  initial begin
    bus.rxBitValid_i  = 1'b0;
    bus.rxBit_i       = 1'b0;
    bus.eopDetected_i = 1'b0;
    tb_ones = 0;
    clr();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    idle(2);
    test_basic_a5();
    test_stuffing();
    test_stuff_error();
    test_sync_hunt();
    test_align();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_sequencer.md
Name: usb_rx_packet_sequencer

Overview:
Receive-side sequencer between the NRZI decoder and the packet/PID layer of the SIE.
- Hunts for the SYNC pattern in the decoded bit stream.
- Runs bit-unstuffing (six-ones rule) on the packet body and assembles LSB-first bytes.
- Frames the packet on EOP and reports stuffing, alignment and overflow errors as single-cycle pulses.

Parameters:
SYNC_MIN_ZEROS, 5, minimum consecutive decoded 0 bits before the terminating 1 that is accepted as SYNC (tolerates leading SYNC bits lost by hubs).
MAX_BYTES, 1027, maximum bytes per packet (PID + 1024 payload + CRC16); one more completed byte is an overflow.

Ports:
clk12_i  input  1  12 MHz clock
rst_i  input  1  synchronous, active-high reset
rxBitValid_i  input  1  rxBit_i holds a decoded bit this cycle
rxBit_i  input  1  NRZI-decoded bit (1 = no line transition)
eopDetected_i  input  1  single-cycle pulse: SE0-SE0-J end of packet seen
rxActive_o  output  1  high from SYNC accept until the packet is closed
byte_o  output  8  assembled byte, LSB received first
byteValid_o  output  1  one-cycle strobe: byte_o is valid
rxDone_o  output  1  one-cycle pulse: packet ended cleanly
stuffError_o  output  1  one-cycle pulse: 7th consecutive 1 seen
alignError_o  output  1  one-cycle pulse: EOP with partial byte or zero bytes
overflowError_o  output  1  one-cycle pulse: byte count exceeded MAX_BYTES

Behaviour:
Reset:
- All outputs are 0; byte_o is 0.
- State is HUNT; zero counter, ones counter, bit counter and byte counter are 0.

State HUNT (rxActive_o = 0):
- A valid 0 bit increments the zero counter, saturating at SYNC_MIN_ZEROS.
- A valid 1 bit with counter == SYNC_MIN_ZEROS goes to DATA, sets the ones counter to 1 (the SYNC trailing 1 counts toward stuffing), and clears the bit and byte counters.
- A valid 1 bit with counter < SYNC_MIN_ZEROS clears the zero counter.
- eopDetected_i clears the zero counter. No other effect.

State DATA (rxActive_o = 1):
- For each valid bit, check the ones counter first:
  - If it equals 6 and the bit is 0: stuffed bit. Drop it and clear the ones counter.
  - If it equals 6 and the bit is 1: pulse stuffError_o next cycle and go to DRAIN.
  - Otherwise: shift the bit into the shift register at MSB (shift right). A 1 increments the ones counter; a 0 clears it. Increment the 3-bit bit counter.
- Byte completion: when the bit counter wraps 7→0, byte_o is loaded and byteValid_o pulses on the next cycle. Latency is one cycle after the 8th data bit is sampled.
- The byte counter increments on each completed byte. If the byte would be number MAX_BYTES+1, it is not emitted; overflowError_o pulses instead and the state goes to DRAIN.
- On eopDetected_i:
  - bit counter == 0 and byte count ≥ 1: rxDone_o pulses next cycle.
  - Otherwise: alignError_o pulses.
  - Either way, go to HUNT and drop rxActive_o in the same update. A pending stuff expectation (ones counter == 6) at EOP is not an error.

State DRAIN (rxActive_o = 1):
- Ignore bits.
- eopDetected_i goes to HUNT with no further pulse.

Simultaneous events:
- eopDetected_i and rxBitValid_i in the same cycle: EOP wins and the bit is discarded, in every state.

Pulses:
- At most one error pulse per packet.
- rxDone_o and any error pulse are mutually exclusive.

rst_i mid-packet:
- Abort immediately to the reset state. No rxDone_o or error pulse is emitted.

Test Plan:
- Bits 0000000 1, then 0xA5 LSB-first (1,0,1,0,0,1,0,1), then EOP → rxActive_o rises after SYNC; byte_o = 0xA5 with byteValid_o one cycle after the 8th bit; rxDone_o pulse; rxActive_o = 0.
- SYNC, then data 0xFF 0x01 with a stuffed 0 inserted after the 5th data 1 (the SYNC trailing 1 counts as the first 1), then EOP → bytes 0xFF, 0x01; no stuffError_o; rxDone_o pulse.
- SYNC, then seven 1 bits → stuffError_o pulse after the 7th 1; following bits ignored; EOP → no rxDone_o; state returns to HUNT.
- Only 4 zeros then 1, then 5 zeros then 1 → first 1 rejected; SYNC accepted on the second 1; rxActive_o = 1.
- SYNC, one full byte plus 3 bits, then EOP → one byteValid_o; alignError_o pulse; no rxDone_o. Also EOP directly after SYNC → alignError_o.
- MAX_BYTES = 2: SYNC plus 3 bytes → two byteValid_o pulses, then overflowError_o. Also: EOP coincident with the 8th bit → byte not emitted, alignError_o pulse. Also: rst_i mid-byte → all outputs 0, HUNT, no pulses.
